// File: rtl/vga_timing_pkg.sv
// VGA raster timing: shared types, standard mode constants and helpers.
// Imported by the timing generator and its delay line.
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        hsync_pol;
        logic        vsync_pol;
    } vga_timing_t;

    // 640x480@60, 25 MHz pixel rate from 100 MHz
    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33,
        hsync_pol: 1'b0, vsync_pol: 1'b0
    };
    localparam int VGA_640X480_60_CLK_DIV = 4;

    // 800x600@72, 50 MHz pixel rate from 100 MHz
    localparam vga_timing_t VGA_800X600_72 = '{
        h_active: 16'd800, h_fp: 16'd56, h_sync: 16'd120, h_bp: 16'd64,
        v_active: 16'd600, v_fp: 16'd37, v_sync: 16'd6,   v_bp: 16'd23,
        hsync_pol: 1'b1, vsync_pol: 1'b1
    };
    localparam int VGA_800X600_72_CLK_DIV = 2;

    function automatic int calc_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_timing_gen_delay_line.sv
// Enable-gated shift register used to align sync/active with pixel data.
// DEPTH of zero is a straight wire.
module vga_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = ^{clk, reset, en_i};
        assign q_o = d_i;
    end else begin : g_regs
        logic [WIDTH-1:0] stage_q [DEPTH];

        // Shift one stage per enable; reset loads the idle value everywhere
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
            end else if (en_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine on the system clock with a pixel
// clock-enable, undelayed coordinates and latency-matched sync/active.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = VGA_640X480_60_CLK_DIV,
    parameter int H_ACTIVE  = int'(VGA_640X480_60.h_active),
    parameter int H_FP      = int'(VGA_640X480_60.h_fp),
    parameter int H_SYNC    = int'(VGA_640X480_60.h_sync),
    parameter int H_BP      = int'(VGA_640X480_60.h_bp),
    parameter int V_ACTIVE  = int'(VGA_640X480_60.v_active),
    parameter int V_FP      = int'(VGA_640X480_60.v_fp),
    parameter int V_SYNC    = int'(VGA_640X480_60.v_sync),
    parameter int V_BP      = int'(VGA_640X480_60.v_bp),
    parameter bit HSYNC_POL = VGA_640X480_60.hsync_pol,
    parameter bit VSYNC_POL = VGA_640X480_60.vsync_pol,
    parameter int PIPE_LAT  = 2,
    parameter int COORD_W   = 10
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pix_ce,
    output logic [COORD_W-1:0] x_pos,
    output logic [COORD_W-1:0] y_pos,
    output logic               req_active,
    output logic               hsync,
    output logic               vsync,
    output logic               vid_active,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_BEG  = H_ACTIVE + H_FP;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FP;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (H_TOTAL > 2**COORD_W || V_TOTAL > 2**COORD_W) begin : g_bad_w
        $error("vga_timing_gen: COORD_W too narrow for raster totals");
    end
    if (PIPE_LAT < 0 || PIPE_LAT > 4 || CLK_DIV < 1) begin : g_bad_p
        $error("vga_timing_gen: PIPE_LAT or CLK_DIV out of range");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
    logic [15:0]        fc_q, fc_d;
    logic               h_wrap, v_wrap;
    logic               hs0, vs0;
    logic [2:0]         dly;

    assign pix_ce = (div_q == DIV_W'(CLK_DIV - 1));
    assign h_wrap = (h_q == COORD_W'(H_TOTAL - 1));
    assign v_wrap = (v_q == COORD_W'(V_TOTAL - 1));

    // Next-state for divider, raster counters and frame counter
    always_comb begin
        div_d = pix_ce ? '0 : div_q + 1'b1;
        h_d   = h_q;
        v_d   = v_q;
        fc_d  = fc_q;
        if (pix_ce) begin
            h_d = h_wrap ? '0 : h_q + 1'b1;
            if (h_wrap) begin
                v_d = v_wrap ? '0 : v_q + 1'b1;
                if (v_wrap) fc_d = fc_q + 16'd1;
            end
        end
    end

    // Counter state, cleared by reset at any point in the frame
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            fc_q  <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            fc_q  <= fc_d;
        end
    end

    assign x_pos       = h_q;
    assign y_pos       = v_q;
    assign frame_count = fc_q;
    assign req_active  = (h_q < COORD_W'(H_ACTIVE)) && (v_q < COORD_W'(V_ACTIVE));
    assign line_start  = pix_ce && (h_q == '0);
    assign frame_start = line_start && (v_q == '0);

    assign hs0 = (h_q >= COORD_W'(HS_BEG)) && (h_q < COORD_W'(HS_END));
    assign vs0 = (v_q >= COORD_W'(VS_BEG)) && (v_q < COORD_W'(VS_END));

    vga_delay_line #(
        .DEPTH   (PIPE_LAT),
        .WIDTH   (3),
        .RST_VAL (3'b000)
    ) u_dly (
        .clk   (clk),
        .reset (reset),
        .en_i  (pix_ce),
        .d_i   ({hs0, vs0, req_active}),
        .q_o   (dly)
    );

    assign hsync      = HSYNC_POL ? dly[2] : ~dly[2];
    assign vsync      = VSYNC_POL ? dly[1] : ~dly[1];
    assign vid_active = dly[0];

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing engine: the next-generation replacement for the fixed 640x480 controller and the divided-clock scheme in the top level. It runs on the 100 MHz system clock and emits a one-cycle pixel clock-enable instead of a derived clock. All horizontal and vertical timing is set by parameters, as are sync polarities. Sync and active outputs are delayed by a configurable pipeline latency so they stay aligned with a downstream pixel source, such as the canvas RAM read, that has fixed latency.

## Interface
- CLK_DIV, 4: system clocks per pixel tick (>=1); 4 gives 25 MHz from 100 MHz.
- H_ACTIVE, 640 / H_FP, 16 / H_SYNC, 96 / H_BP, 48: horizontal segments in pixel ticks, each >=1.
- V_ACTIVE, 480 / V_FP, 10 / V_SYNC, 2 / V_BP, 33: vertical segments in lines, each >=1.
- HSYNC_POL, 0 / VSYNC_POL, 0: sync level during the pulse (0 = active-low).
- PIPE_LAT, 2: pixel-tick delay from x_pos/y_pos to hsync/vsync/vid_active; range 0..4.
- COORD_W, 10: width of the coordinate outputs. Elaboration error if H_TOTAL or V_TOTAL > 2**COORD_W.
- clk  in  1  system clock (100 MHz).
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- pix_ce  out  1  one-clk-wide pixel tick enable.
- x_pos  out  COORD_W  current horizontal count, 0..H_TOTAL-1 (undelayed).
- y_pos  out  COORD_W  current line count, 0..V_TOTAL-1 (undelayed).
- req_active  out  1  x_pos<H_ACTIVE && y_pos<V_ACTIVE (undelayed; drives pixel fetch).
- hsync, vsync  out  1  delayed sync outputs.
- vid_active  out  1  delayed active-video flag.
- line_start  out  1  pix_ce && x_pos==0.
- frame_start  out  1  pix_ce && x_pos==0 && y_pos==0.
- frame_count  out  16  completed-frame counter.

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Divider: div counts 0..CLK_DIV-1 every clk and wraps. pix_ce = (div==CLK_DIV-1). CLK_DIV=1 gives pix_ce constantly high.
- Counters advance only on clk edges with pix_ce high:
  - h increments and wraps at H_TOTAL-1 to 0.
  - v increments when h wraps, and wraps at V_TOTAL-1 to 0.
  - frame_count increments (mod 2^16) when both h and v wrap.
- Decode, stage 0, combinational from h and v:
  - hs0 = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs0 = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - act0 = req_active.
- Delay line: PIPE_LAT registered stages, shifted only on pix_ce.
  - PIPE_LAT=0: outputs are stage 0 directly.
  - hsync = HSYNC_POL when the delayed hs is set, else ~HSYNC_POL; vsync likewise with VSYNC_POL.
- Reset (any cycle, including mid-frame):
  - div, h, v, frame_count = 0.
  - All delay stages = inactive (sync deasserted, active 0).
- Outputs in the first cycle after reset:
  - pix_ce=0 (unless CLK_DIV=1).
  - x_pos=y_pos=0, req_active=1.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL, vid_active=0 until PIPE_LAT ticks have elapsed.
  - line_start and frame_start follow pix_ce.

## Timing
- The first pix_ce after reset release occurs CLK_DIV-1 clks later, at cycle index CLK_DIV-1 with cycle 0 being the first non-reset cycle. It coincides with frame_start=1.
- Output-to-output alignment:
  - hsync/vsync/vid_active during tick n equal the decode of position n-PIPE_LAT.
  - x_pos/y_pos/req_active are aligned with position n.
- The line_start and frame_start pulses are exactly one clk wide and occur once per line and once per frame respectively.
- When the counters wrap, frame_count updates on the same edge. It is visible alongside the frame_start of the new frame.

## Structure
- Package vga_timing_pkg:
  - Struct vga_timing_t holding the eight segment lengths and two polarities.
  - Constants VGA_640X480_60 (CLK_DIV 4) and VGA_800X600_72 (50 MHz, CLK_DIV 2).
  - Function calc_total().
- Sub-module vga_delay_line: parametrised depth and width, shift on enable, synchronous reset to a parameter value.
- Top-level replacement wires pix_ce as the clock-enable for the canvas and controller logic. It no longer derives a fabric clock.

## Test plan
- Defaults, run 2 frames:
  - pix_ce period 4 clks.
  - frame_start spacing 1,680,000 clks.
  - frame_count 0 -> 1 -> 2.
- Defaults, PIPE_LAT=2:
  - hsync falls on the tick where x_pos==658 and stays low for 96 ticks.
  - vsync low for 2 lines starting where y_pos==490 (delayed 2 ticks).
- Tiny timing: H 4/1/2/1, V 3/1/1/1, CLK_DIV=1, PIPE_LAT=0.
  - frame_start every 48 clks.
  - vid_active high for 12 ticks per frame.
  - hsync low at x=5,6.
- Mid-frame reset at x=300, y=200:
  - Next cycle x_pos=y_pos=0, frame_count=0, hsync/vsync inactive, vid_active=0.
  - vid_active held 0 for PIPE_LAT ticks.
- HSYNC_POL=1, VSYNC_POL=1: sync idles low and pulses high with identical timing to the active-low case.
- frame_count wrap: force 16'hFFFF, end the frame -> 16'h0000.
